calculation_dispatcher: RTL and testbench
=========================================

# calculation_dispatcher

Issue/retire controller for the pipe-3 ALU. Accepts operations from pipe 2 over a valid/ready handshake and issues each one to a free multi-cycle calculation unit using that unit's `newCalculation`/`rdy` protocol. It captures each unit's result when the unit finishes and hands results to pipe 4 in strict acceptance order over a valid/ready handshake. It is the initiator side of the calculation-unit protocol.

## Interface
- `NUM_UNITS`, 4: number of identical calculation units driven; ≥1, power of two.
- `CALCULATION_WIDTH`, 27: operand/result width.
- `TAG_WIDTH`, 4: opaque tag carried with each operation.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation offered by pipe 2.
- `in_ready` out 1: dispatcher can accept this cycle.
- `in_data` in CALCULATION_WIDTH: operand.
- `in_tag` in TAG_WIDTH: tag.
- `unit_new` out NUM_UNITS: per-unit `newCalculation` pulse.
- `unit_operand` out NUM_UNITS×CALCULATION_WIDTH: per-unit operand; held stable while that unit is busy.
- `unit_rdy` in NUM_UNITS: per-unit `rdy`.
- `unit_result` in NUM_UNITS×CALCULATION_WIDTH: per-unit `calculation_o`.
- `out_valid` out 1: result available to pipe 4.
- `out_ready` in 1: pipe 4 accepts.
- `out_data` out CALCULATION_WIDTH: result.
- `out_tag` out TAG_WIDTH: tag of that result.

## Operation
- Per-unit state (package enum `unit_state_t`): IDLE → ISSUE → PENDING → DONE → IDLE.
  - IDLE: unit is free when the state is IDLE and `unit_rdy[k]` is 1.
  - Accept: when `in_valid && in_ready`, choose the free unit with the lowest index at or after `rr_ptr` (wrapping). Load `unit_operand[k]` and `tag[k]`, set the state to ISSUE, and push `k` into the order FIFO. Set `rr_ptr` to `k+1` mod `NUM_UNITS`.
  - ISSUE: `unit_new[k]` = 1 for exactly this one cycle (registered output). Next state is PENDING.
  - PENDING: wait for `unit_rdy[k]`. When it is 1, capture `unit_result[k]` into `hold[k]` and go to DONE. `unit_rdy` is ignored in the ISSUE cycle.
  - DONE: stay until this unit is the order-FIFO head and `out_valid && out_ready`; then go to IDLE.
- `in_ready` = OR of free units (combinational). The order FIFO (depth `NUM_UNITS`) can never overflow, because each entry occupies a non-IDLE unit.
- `out_valid` = FIFO not empty and `state[head]` == DONE. `out_data` = `hold[head]`, `out_tag` = `tag[head]`.
- Retire and accept in the same cycle: FIFO push and pop both happen. A unit that retires this cycle is not free until the next cycle, because free is computed from registered state.
- Outputs are in acceptance order even when units finish out of order.
- Reset (any time, including mid-operation): all units go to IDLE, the FIFO empties, `rr_ptr` = 0, and `unit_new` = 0. In-flight operations are dropped. Reset values: `in_ready` = 0 during reset (follows `unit_rdy`, which the units force to 0), `out_valid` = 0, `unit_new` = 0, `unit_operand`/`hold`/tag = 0, `out_data` = 0, `out_tag` = 0.

## Timing
- Unit latency is C = the unit's `CYCLES_TO_COMPLETE`.
- The cycle sequence from an accept at edge E0:
  - `unit_new` is high for cycle E0–E1.
  - The unit counts from E1.
  - `unit_rdy` goes high after edge E_C.
  - Capture happens at E_(C+1), and `out_valid` is high after E_(C+1).
- Accept-to-`out_valid` latency is C+1 cycles. The rule holds for C = 1 (`rdy` never drops).
- With 4 units and C = 4, sustained throughput is 4 accepts per 6 cycles per unit cycle (each unit spends 1 + C + 1 cycles per operation). Back-to-back accepts to different units are allowed every cycle.
- `out_valid`/`out_data`/`out_tag` stay stable while `out_ready` = 0.

## Structure
- Package `gpu_alu_pkg` holds `unit_state_t`, `unit_idx_t` (`$clog2(NUM_UNITS)` bits), and the default width constants `CALCULATION_WIDTH_DEFAULT` and `TAG_WIDTH_DEFAULT`.
- Sub-module `unit_order_fifo`: a synchronous FIFO of `unit_idx_t`, depth `NUM_UNITS`, with simultaneous push/pop, empty/full flags, and asynchronous active-low reset.
- The round-robin selector is a function inside the dispatcher.

## Test plan
- Single op, 4 units of C = 4: `in_data` = 0x000_1234, tag 3, `out_ready` = 1 → `unit_new[0]` pulses once; `out_valid` arrives 5 cycles after accept with tag 3 and the data from unit 0.
- Burst of 6 ops, tags 0–5, `in_valid` held high → accepts go to units 0, 1, 2, 3 on consecutive cycles; `in_ready` drops; units 0 and 1 are reused after they retire; outputs come out in tag order 0–5.
- Out-of-order finish: the bench holds unit 0's `rdy` low 3 extra cycles; unit 1 finishes first → unit 1's result is held in DONE, and `out_valid` stays low until unit 0 completes; then tag 0 and tag 1 come out on consecutive cycles.
- Backpressure: `out_ready` = 0 for 10 cycles after 4 accepts → `in_ready` = 0 once all units are DONE; the outputs are stable; after release, retire and accept happen in the same cycle.
- Reset mid-operation: assert `rst` low while 2 ops are PENDING → all outputs are 0 immediately; after release, `rr_ptr` = 0 and the next op goes to unit 0 with no stale outputs.
- C = 1 units: ops every cycle → latency is 2 cycles and all tags are retired in order.

Source files
------------

// File: rtl/gpu_alu_pkg.sv
// Shared types and default widths for the pipe-3 ALU dispatcher and its helpers.
package gpu_alu_pkg;

  localparam int NUM_UNITS_DEFAULT         = 4;
  localparam int CALCULATION_WIDTH_DEFAULT = 27;
  localparam int TAG_WIDTH_DEFAULT         = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    PENDING,
    DONE
  } unit_state_t;

  typedef logic [$clog2(NUM_UNITS_DEFAULT)-1:0] unit_idx_t;

  // A single unit still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_order_fifo.sv
// Acceptance-order FIFO of unit indices; push and pop may happen in the same cycle.
module unit_order_fifo
  import gpu_alu_pkg::*;
#(
  parameter int  DEPTH = NUM_UNITS_DEFAULT,
  parameter type idx_t = unit_idx_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  idx_t push_data,
  input  logic pop,
  output idx_t pop_data,
  output logic empty,
  output logic full
);

  localparam int PW = idx_width(DEPTH);

  idx_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == (PW + 1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset as well so the head entry reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/calculation_dispatcher.sv
// Issues pipe-2 operations to free calculation units and retires results to pipe 4
// in acceptance order.
module calculation_dispatcher
  import gpu_alu_pkg::*;
#(
  parameter int NUM_UNITS         = NUM_UNITS_DEFAULT,
  parameter int CALCULATION_WIDTH = CALCULATION_WIDTH_DEFAULT,
  parameter int TAG_WIDTH         = TAG_WIDTH_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CALCULATION_WIDTH-1:0]           in_data,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  output logic [NUM_UNITS-1:0]                   unit_new,
  output logic [NUM_UNITS*CALCULATION_WIDTH-1:0] unit_operand,
  input  logic [NUM_UNITS-1:0]                   unit_rdy,
  input  logic [NUM_UNITS*CALCULATION_WIDTH-1:0] unit_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CALCULATION_WIDTH-1:0]           out_data,
  output logic [TAG_WIDTH-1:0]                   out_tag
);

  localparam int IW = idx_width(NUM_UNITS);
  typedef logic [IW-1:0] idx_t;

  unit_state_t                  state_q   [NUM_UNITS];
  unit_state_t                  state_d   [NUM_UNITS];
  logic [CALCULATION_WIDTH-1:0] operand_q [NUM_UNITS];
  logic [CALCULATION_WIDTH-1:0] hold_q    [NUM_UNITS];
  logic [TAG_WIDTH-1:0]         tag_q     [NUM_UNITS];
  logic [NUM_UNITS-1:0]         free;
  logic [NUM_UNITS-1:0]         new_q;
  idx_t                         rr_ptr;
  idx_t                         sel;
  idx_t                         head;
  logic                         accept;
  logic                         retire;
  logic                         fifo_empty;
  logic                         fifo_full;

  // First free unit at or after ptr, wrapping; later iterations win so the lowest offset is kept.
  function automatic idx_t pick_unit(input logic [NUM_UNITS-1:0] f, input idx_t ptr);
    idx_t r;
    r = ptr;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (f[(int'(ptr) + i) % NUM_UNITS]) r = idx_t'((int'(ptr) + i) % NUM_UNITS);
    end
    return r;
  endfunction

  always_comb begin
    free = '0;
    for (int k = 0; k < NUM_UNITS; k++) free[k] = (state_q[k] == IDLE) && unit_rdy[k];
  end

  assign in_ready  = |free;
  assign accept    = in_valid && in_ready;
  assign sel       = pick_unit(free, rr_ptr);
  assign out_valid = !fifo_empty && (state_q[head] == DONE);
  assign retire    = out_valid && out_ready;
  assign out_data  = hold_q[head];
  assign out_tag   = tag_q[head];
  assign unit_new  = new_q;

  always_comb begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      // NOTE: hold-by-default assignment first keeps every path assigned, so no latch is inferred.
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE:    if (accept && sel == idx_t'(k)) state_d[k] = ISSUE;
        ISSUE:   state_d[k] = PENDING;
        PENDING: if (unit_rdy[k]) state_d[k] = DONE;
        DONE:    if (retire && head == idx_t'(k)) state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_UNITS; k++) state_q[k] <= IDLE;
    end else begin
      // NOTE: non-blocking updates so all flops sample pre-edge values regardless of statement order.
      for (int k = 0; k < NUM_UNITS; k++) state_q[k] <= state_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      new_q  <= '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
        operand_q[k] <= '0;
        hold_q[k]    <= '0;
        tag_q[k]     <= '0;
      end
    end else begin
      if (accept) rr_ptr <= (sel == idx_t'(NUM_UNITS - 1)) ? '0 : sel + 1'b1;
      for (int k = 0; k < NUM_UNITS; k++) begin
        new_q[k] <= accept && (sel == idx_t'(k));
        if (accept && sel == idx_t'(k)) begin
          operand_q[k] <= in_data;
          tag_q[k]     <= in_tag;
        end
        if (state_q[k] == PENDING && unit_rdy[k])
          hold_q[k] <= unit_result[k*CALCULATION_WIDTH +: CALCULATION_WIDTH];
      end
    end
  end

  always_comb begin
    unit_operand = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      unit_operand[k*CALCULATION_WIDTH +: CALCULATION_WIDTH] = operand_q[k];
  end

  unit_order_fifo #(
    .DEPTH (NUM_UNITS),
    .idx_t (idx_t)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (sel),
    .pop       (retire),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Every FIFO entry owns a non-IDLE unit, so a full FIFO means nothing is free to accept.
  assert property (@(posedge clk) disable iff (!rst) !(accept && fifo_full && !retire));

endmodule

// File: tb/tb_calculation_dispatcher.sv
// Self-checking bench: behavioural calculation units, an acceptance-order scoreboard,
// directed corner-case sequences and randomized traffic.
module tb_calculation_dispatcher;

  localparam int N  = 4;
  localparam int CW = 27;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   in_data = '0;
  logic [TW-1:0]   in_tag = '0;
  logic [N-1:0]    unit_new;
  logic [N*CW-1:0] unit_operand;
  logic [N-1:0]    unit_rdy;
  logic [N*CW-1:0] unit_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_data;
  logic [TW-1:0]   out_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 4;
  int extra [N];
  bit rand_extra = 1'b0;
  bit chk_lat    = 1'b0;
  int cycle      = 0;

  typedef struct {
    logic [CW-1:0] data;
    logic [TW-1:0] tag;
    int            t;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [CW-1:0] data;
    logic [TW-1:0] tag;
    int            unit_exp;
    int            lat_exp;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  calculation_dispatcher #(
    .NUM_UNITS         (N),
    .CALCULATION_WIDTH (CW),
    .TAG_WIDTH         (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_tag       (in_tag),
    .unit_new     (unit_new),
    .unit_operand (unit_operand),
    .unit_rdy     (unit_rdy),
    .unit_result  (unit_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag)
  );

  function automatic logic [CW-1:0] ref_calc(input logic [CW-1:0] d);
    return (d * 27'd3) + 27'd1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Calculation unit: rdy drops after it sees newCalculation and rises C edges after the pulse.
  for (genvar k = 0; k < N; k++) begin : g_unit
    logic r;
    int   c;
    int   d;
    assign unit_rdy[k] = r;
    assign unit_result[k*CW +: CW] = ref_calc(unit_operand[k*CW +: CW]);
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        r <= 1'b0;
        c <= 0;
      end else if (unit_new[k]) begin
        d = cyc - 1 + (rand_extra ? int'($urandom_range(3, 0)) : extra[k]);
        c <= d;
        r <= (d == 0);
      end else if (c > 0) begin
        c <= c - 1;
        r <= (c == 1);
      end else begin
        r <= 1'b1;
      end
    end
  end

  // Scoreboard: results must leave in acceptance order with the unit's computed value.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_out_tag", out_tag, e.tag);
          check("sb_out_data", out_data, e.data);
          // Accept is sampled half a cycle before its edge, hence the extra -1.
          if (chk_lat) check("sb_accept_to_valid", cycle - e.t - 1, cyc + 1);
        end
      end
      if (in_valid && in_ready) sb.push_back('{ref_calc(in_data), in_tag, cycle});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_unit_new", unit_new, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_unit_operand", unit_operand, 0);
    step();
    step();
    rst = 1'b1;
    step();
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run_single(input vec_t v);
    int lat;
    bit seen;
    in_valid = 1'b1;
    in_data = v.data;
    in_tag = v.tag;
    check("single_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("single_unit_new", unit_new, N'(1) << v.unit_exp);
    check("single_operand", unit_operand[v.unit_exp*CW +: CW], v.data);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      lat++;
      if (i == 0) check("single_new_one_cycle", unit_new, 0);
      if (out_valid) seen = 1'b1;
    end
    check("single_latency", lat, v.lat_exp);
    check("single_out_tag", out_tag, v.tag);
    check("single_out_data", out_data, ref_calc(v.data));
    step();
    check("single_retired", out_valid, 0);
  endtask

  initial begin
    int   unit_seq [$];
    int   acc_t [$];
    int   i;
    int   rel;
    int   first;
    bit   not_ready_seen;
    logic [CW-1:0] d0;

    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   unit_seq [$];
    int   acc_t [$];
    int   n;
    int   rel;
    int   first;
    bit   not_ready_seen;
    logic [CW-1:0] held_data;

    for (int k = 0; k < N; k++) extra[k] = 0;
    vecs[0] = '{27'h0001234, 4'd3, 0, 5};
    vecs[1] = '{27'h5555555, 4'hA, 1, 5};
    vecs[2] = '{27'h7FFFFFF, 4'hF, 2, 5};
    vecs[3] = '{27'h0000000, 4'h0, 3, 5};
    vecs[4] = '{27'h2468ACE, 4'h6, 0, 5};

    // Single ops through each unit in round-robin order.
    do_reset();
    out_ready = 1'b1;
    chk_lat = 1'b1;
    for (int v = 0; v < 5; v++) run_single(vecs[v]);

    // Burst of 6 with in_valid held high.
    do_reset();
    not_ready_seen = 1'b0;
    n = 0;
    for (int t = 0; t < 100 && n < 6; t++) begin
      in_valid = 1'b1;
      in_tag = TW'(n);
      in_data = CW'($urandom);
      if (in_ready) begin
        step();
        unit_seq.push_back(oh_idx(unit_new));
        acc_t.push_back(t);
        n++;
      end else begin
        not_ready_seen = 1'b1;
        step();
      end
    end
    in_valid = 1'b0;
    check("burst_all_accepted", n, 6);
    if (n == 6) begin
      check("burst_unit0", unit_seq[0], 0);
      check("burst_unit1", unit_seq[1], 1);
      check("burst_unit2", unit_seq[2], 2);
      check("burst_unit3", unit_seq[3], 3);
      check("burst_reuse0", unit_seq[4], 0);
      check("burst_reuse1", unit_seq[5], 1);
      check("burst_back_to_back", acc_t[3] - acc_t[0], 3);
    end
    check("burst_in_ready_dropped", not_ready_seen, 1);
    drain();

    // Unit 0 finishes 3 cycles late; unit 1 must wait behind it.
    do_reset();
    chk_lat = 1'b0;
    extra[0] = 3;
    in_valid = 1'b1;
    in_data = 27'h0000111;
    in_tag = 4'd0;
    step();
    in_data = 27'h0000222;
    in_tag = 4'd1;
    step();
    in_valid = 1'b0;
    rel = 1;
    first = -1;
    for (int t = 0; t < 20 && first < 0; t++) begin
      if (out_valid) first = rel;
      else begin
        step();
        rel++;
      end
    end
    check("ooo_first_valid_cycle", first, 8);
    check("ooo_first_tag", out_tag, 0);
    step();
    check("ooo_second_valid", out_valid, 1);
    check("ooo_second_tag", out_tag, 1);
    step();
    check("ooo_done", out_valid, 0);
    extra[0] = 0;
    drain();

    // Backpressure with all units DONE, then simultaneous retire and accept.
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      in_tag = TW'(t);
      in_data = CW'(32'h100 + t);
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) step();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_tag", out_tag, 0);
    check("bp_out_data", out_data, ref_calc(27'h100));
    held_data = out_data;
    for (int t = 0; t < 3; t++) begin
      step();
      check("bp_stable_valid", out_valid, 1);
      check("bp_stable_data", out_data, held_data);
      check("bp_stable_tag", out_tag, 0);
    end
    in_valid = 1'b1;
    in_tag = 4'd4;
    in_data = 27'h0ABCDEF;
    out_ready = 1'b1;
    step();
    check("bp_accept_ready", in_ready, 1);
    check("bp_retire_valid", out_valid, 1);
    step();
    in_valid = 1'b0;
    check("bp_reaccept_unit0", unit_new, 4'b0001);
    drain();

    // Reset while two operations are pending.
    do_reset();
    in_valid = 1'b1;
    in_data = 27'h0000AAA;
    in_tag = 4'd1;
    step();
    in_data = 27'h0000BBB;
    in_tag = 4'd2;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_unit_new", unit_new, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_operand", unit_operand, 0);
    step();
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      check("midrst_no_stale", out_valid, 0);
    end
    chk_lat = 1'b1;
    run_single('{27'h0003C3C, 4'd7, 0, 5});

    // Single-cycle units: accepts every cycle, latency 2.
    cyc = 1;
    do_reset();
    n = 0;
    for (int t = 0; t < 12; t++) begin
      in_valid = 1'b1;
      in_tag = TW'(t);
      in_data = CW'($urandom);
      if (in_ready) n++;
      step();
    end
    in_valid = 1'b0;
    check("c1_accept_every_cycle", n, 12);
    drain();

    // Randomized traffic with random unit delays and random backpressure.
    cyc = 4;
    do_reset();
    chk_lat = 1'b0;
    rand_extra = 1'b1;
    for (int t = 0; t < 400; t++) begin
      in_valid = ($urandom_range(99, 0) < 60);
      in_data = CW'($urandom);
      in_tag = TW'($urandom);
      out_ready = ($urandom_range(99, 0) < 70);
      step();
    end
    drain();
    rand_extra = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
